// File: rtl/bus_timer_io.sv
// bus_timer_io
//   Memory-mapped responder on the processor bus. It holds a prescaled 16-bit
//   down-counting delay timer and a switch input port. Read data is registered,
//   so it is valid one clock after the address, with the same timing as the
//   synchronous instruction memory.
//
//   Register map (offset = ADDR[2:0]; ADDR[11:3] is ignored, so registers alias):
//     0 RELOAD  r/w
//     1 CTRL    r/w  bit0 EN, bit1 AUTO
//     2 COUNT   r
//     3 STATUS  r    bit0 DONE, clear-on-read (a simultaneous set wins)
//     4 SWIN    r    switch value
//     5..7      read 0
//
//   Ports:
//     Clock        system clock, rising edge
//     Reset        synchronous, active-high
//     ADDR[15:0]   processor address; ADDR[15:12] == BASE selects this block
//     DOUT[15:0]   processor write data
//     W            processor write strobe
//     SW[15:0]     slide switches (asynchronous)
//     Q[15:0]      registered read data, 0 when no read is selected
//     CS_Q         registered read-select for the DIN mux
//     DONE         sticky timer-expired flag
//
//   Build option: define SW_SYNC_EN to pass SW through a two-flop synchronizer
//   before SWIN. When it is undefined, SW is sampled directly by the read
//   register, which is only safe if SW is synchronized upstream.

module bus_timer_io #(
  parameter logic [3:0]  BASE     = 4'h3,
  parameter int unsigned PRESCALE = 50000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] ADDR,
  input  logic [15:0] DOUT,
  input  logic        W,
  input  logic [15:0] SW,
  output logic [15:0] Q,
  output logic        CS_Q,
  output logic        DONE
);

  localparam logic [15:0] PS_LAST    = 16'(PRESCALE - 1);
  localparam logic [2:0]  OFF_RELOAD = 3'd0;
  localparam logic [2:0]  OFF_CTRL   = 3'd1;
  localparam logic [2:0]  OFF_COUNT  = 3'd2;
  localparam logic [2:0]  OFF_STATUS = 3'd3;
  localparam logic [2:0]  OFF_SWIN   = 3'd4;

  // Bus decode
  logic       cs;
  logic       wr_en;
  logic       rd_en;
  logic [2:0] off;
  logic       ctrl_wr;
  logic       status_rd;
  logic       addr_unused;

  always_comb begin
    cs        = (ADDR[15:12] == BASE);
    wr_en     = cs & W;
    rd_en     = cs & ~W;
    off       = ADDR[2:0];
    ctrl_wr   = wr_en && (off == OFF_CTRL);
    status_rd = rd_en && (off == OFF_STATUS);
  end

  // Middle address bits deliberately take no part in decode.
  assign addr_unused = ^ADDR[11:3];

  // Timer state
  logic [15:0] reload;
  logic [15:0] count;
  logic [15:0] presc;
  logic        en;
  logic        auto_rl;
  logic        done;

  logic [15:0] count_n;
  logic [15:0] presc_n;
  logic        en_n;
  logic        auto_n;
  logic        done_set;
  logic        tick;
  logic        run;
  logic        start;

  always_comb begin
    tick  = en && (presc == PS_LAST);
    // An EN 0->1 write restarts the timer; an EN=0 write freezes it this edge.
    start = ctrl_wr && !en && DOUT[0];
    run   = en && !(ctrl_wr && !DOUT[0]);

    count_n  = count;
    presc_n  = presc;
    en_n     = en;
    auto_n   = auto_rl;
    done_set = 1'b0;

    if (ctrl_wr) begin
      en_n   = DOUT[0];
      auto_n = DOUT[1];
    end

    if (start) begin
      count_n = reload;
      presc_n = 16'd0;
    end else if (run) begin
      if (count == 16'd0) begin
        // Started with RELOAD == 0: expire immediately rather than run at 0.
        en_n     = 1'b0;
        done_set = 1'b1;
      end else begin
        presc_n = tick ? 16'd0 : presc + 16'd1;
        if (tick) begin
          if (count != 16'd1) begin
            count_n = count - 16'd1;
          end else begin
            done_set = 1'b1;
            if (auto_rl && (reload != 16'd0)) begin
              count_n = reload;
            end else begin
              count_n = 16'd0;
              en_n    = 1'b0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      reload  <= 16'd0;
      count   <= 16'd0;
      presc   <= 16'd0;
      en      <= 1'b0;
      auto_rl <= 1'b0;
      done    <= 1'b0;
    end else begin
      if (wr_en && (off == OFF_RELOAD)) begin
        reload <= DOUT;
      end
      count   <= count_n;
      presc   <= presc_n;
      en      <= en_n;
      auto_rl <= auto_n;
      // Set has priority over clear-on-read.
      done    <= (done & ~status_rd) | done_set;
    end
  end

  assign DONE = done;

  // Switch input
  logic [15:0] swin;

`ifdef SW_SYNC_EN
  logic [15:0] sw_p1;
  logic [15:0] sw_p2;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sw_p1 <= 16'd0;
      sw_p2 <= 16'd0;
    end else begin
      sw_p1 <= SW;
      sw_p2 <= sw_p1;
    end
  end

  assign swin = sw_p2;
`else
  assign swin = SW;
`endif

  // Read mux (stage 0: combinational, pre-edge register values)
  logic [15:0] rd_data_p0;

  always_comb begin
    rd_data_p0 = 16'd0;
    case (off)
      OFF_RELOAD: rd_data_p0 = reload;
      OFF_CTRL:   rd_data_p0 = {14'd0, auto_rl, en};
      OFF_COUNT:  rd_data_p0 = count;
      OFF_STATUS: rd_data_p0 = {15'd0, done};
      OFF_SWIN:   rd_data_p0 = swin;
      default:    rd_data_p0 = 16'd0;
    endcase
  end

  // Stage 1: registered read data and select
  logic [15:0] q_p1;
  logic        vld_p1;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      q_p1   <= 16'd0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= rd_en;
      q_p1   <= rd_en ? rd_data_p0 : 16'd0;
    end
  end

  assign Q    = q_p1;
  assign CS_Q = vld_p1;

endmodule

// File: tb/tb_bus_timer_io.sv
// Testbench for bus_timer_io with PRESCALE = 4. Reads push their expected
// data into a queue; a monitor on the falling edge pops and compares whenever
// CS_Q is high, and checks that Q is 0 otherwise.

module tb_bus_timer_io;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] ADDR;
  logic [15:0] DOUT;
  logic        W;
  logic [15:0] SW;
  logic [15:0] Q;
  logic        CS_Q;
  logic        DONE;

  int errors = 0;
  int checks = 0;
  bit mon_on = 1'b0;
  logic [15:0] exp_q[$];

  bus_timer_io #(
    .BASE    (4'h3),
    .PRESCALE(4)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .ADDR (ADDR),
    .DOUT (DOUT),
    .W    (W),
    .SW   (SW),
    .Q    (Q),
    .CS_Q (CS_Q),
    .DONE (DONE)
  );

  always #5 Clock = ~Clock;

  function automatic logic [15:0] a(input logic [2:0] off);
    return {4'h3, 9'h000, off};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) step();
  endtask

  task automatic rd(input logic [15:0] addr, input logic [15:0] exp);
    ADDR = addr;
    W    = 1'b0;
    exp_q.push_back(exp);
    step();
    ADDR = 16'h0000;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [15:0] data);
    ADDR = addr;
    DOUT = data;
    W    = 1'b1;
    step();
    W    = 1'b0;
    ADDR = 16'h0000;
  endtask

  // Monitor
  always @(negedge Clock) begin
    if (mon_on) begin
      if (CS_Q === 1'b1) begin
        if (exp_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_read: got q=%h expected no read", Q);
        end else begin
          check("read_data", Q, exp_q.pop_front());
        end
      end else begin
        check("idle_q", Q, 16'h0000);
      end
    end
  end

  initial begin
    Reset = 1'b1;
    ADDR  = 16'h0000;
    DOUT  = 16'h0000;
    W     = 1'b0;
    SW    = 16'h0000;
    ticks(2);
    Reset = 1'b0;
    check("reset_q", Q, 16'h0000);
    check("reset_cs_q", {15'd0, CS_Q}, 16'h0000);
    check("reset_done", {15'd0, DONE}, 16'h0000);
    mon_on = 1'b1;

    // Reset state of every offset, back-to-back
    for (int i = 0; i < 8; i++) rd(a(3'(i)), 16'h0000);

    // Register access, aliasing, ignored writes, deselected access
    wr(a(0), 16'h1234);
    rd(16'h3AB8, 16'h1234);
    wr(a(2), 16'hFFFF);
    rd(a(2), 16'h0000);
    wr(a(1), 16'hFFF2);
    rd(a(1), 16'h0002);
    wr(a(1), 16'h0000);
    wr(16'h5000, 16'h7777);
    rd(a(0), 16'h1234);
    ADDR = 16'h4001;
    W    = 1'b0;
    step();
    ADDR = 16'h0000;
    check("desel_cs_q", {15'd0, CS_Q}, 16'h0000);
    check("desel_q", Q, 16'h0000);

    // One-shot: RELOAD 3 x PRESCALE 4 = 12 cycles
    wr(a(0), 16'd3);
    wr(a(1), 16'h0001);
    ticks(11);
    check("oneshot_before_12", {15'd0, DONE}, 16'h0000);
    step();
    check("oneshot_at_12", {15'd0, DONE}, 16'h0001);
    rd(a(2), 16'h0000);
    rd(a(1), 16'h0000);
    rd(a(3), 16'h0001);
    rd(a(3), 16'h0000);

    // RELOAD 0: expires on the edge after enabling
    wr(a(0), 16'd0);
    wr(a(1), 16'h0001);
    check("zero_reload_wait", {15'd0, DONE}, 16'h0000);
    step();
    check("zero_reload_done", {15'd0, DONE}, 16'h0001);
    rd(a(1), 16'h0000);
    rd(a(2), 16'h0000);
    rd(a(3), 16'h0001);
    check("zero_reload_clr", {15'd0, DONE}, 16'h0000);

    // Auto reload: RELOAD 2 -> expiry every 8 cycles
    wr(a(0), 16'd2);
    wr(a(1), 16'h0003);
    ticks(7);
    check("auto_before_8", {15'd0, DONE}, 16'h0000);
    step();
    check("auto_at_8", {15'd0, DONE}, 16'h0001);
    rd(a(3), 16'h0001);
    check("auto_clr", {15'd0, DONE}, 16'h0000);
    ticks(6);
    check("auto_before_16", {15'd0, DONE}, 16'h0000);
    step();
    check("auto_at_16", {15'd0, DONE}, 16'h0001);
    rd(a(2), 16'd2);
    rd(a(3), 16'h0001);
    check("auto_clr2", {15'd0, DONE}, 16'h0000);

    // STATUS read on the expiry edge: Q shows 0, set wins
    ticks(5);
    rd(a(3), 16'h0000);
    check("set_wins_done", {15'd0, DONE}, 16'h0001);
    rd(a(3), 16'h0001);
    check("set_wins_clr", {15'd0, DONE}, 16'h0000);

    // Halt with EN = 0: COUNT holds, no further expiry
    wr(a(1), 16'h0000);
    rd(a(2), 16'd2);
    rd(a(1), 16'h0000);
    ticks(10);
    check("halted_no_done", {15'd0, DONE}, 16'h0000);

    // Switch input
`ifdef SW_SYNC_EN
    SW = 16'hA5C3;
    step();
    rd(a(4), 16'h0000);
    rd(a(4), 16'hA5C3);
`else
    SW = 16'hA5C3;
    rd(a(4), 16'hA5C3);
    SW = 16'h0F0F;
    rd(a(4), 16'h0F0F);
`endif

    // Reset mid-count (COUNT 5) and during a read, with DONE already set
    wr(a(0), 16'd0);
    wr(a(1), 16'h0001);
    step();
    check("pre_reset_done", {15'd0, DONE}, 16'h0001);
    wr(a(0), 16'd5);
    wr(a(1), 16'h0001);
    rd(a(2), 16'd5);
    step();
    ADDR  = a(2);
    W     = 1'b0;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    ADDR  = 16'h0000;
    check("rst_q", Q, 16'h0000);
    check("rst_cs_q", {15'd0, CS_Q}, 16'h0000);
    check("rst_done", {15'd0, DONE}, 16'h0000);
    rd(a(2), 16'h0000);
    rd(a(1), 16'h0000);
    rd(a(0), 16'h0000);
    for (int i = 0; i < 30; i++) begin
      step();
      check("rst_no_done", {15'd0, DONE}, 16'h0000);
    end

    ticks(2);
    check("pending_reads", 16'(exp_q.size()), 16'h0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
